// File: rtl/usb_sie_pkg.sv
// Shared SIE types: Tx arbiter FSM states, arbitration modes, idle line levels.
// Used by usb_tx_wire_arb_n and usb_arb_pick.
package usb_sie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  localparam logic [1:0] IDLE_TXBITS = 2'b00;
  localparam logic       IDLE_TXCTL  = 1'b0;
  localparam logic       IDLE_FSRATE = 1'b1;

endpackage

// File: rtl/usb_arb_pick.sv
// Combinational requester pick: lowest index (fixed)
// or first eligible after the last grant (round-robin).
import usb_sie_pkg::*;

module usb_arb_pick #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [IW-1:0]      last_i,
  input  logic               mode_i,
  output logic [NUM_REQ-1:0] pick_o,
  output logic               valid_o
);

  int idx;

  // Scan from the far end so the nearest candidate is the last write.
  always_comb begin
    pick_o  = '0;
    valid_o = |elig_i;
    idx     = 0;
    if (mode_i) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx = (int'(last_i) + k) % NUM_REQ;
        if (elig_i[idx]) begin
          pick_o      = '0;
          pick_o[idx] = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (elig_i[i]) begin
          pick_o    = '0;
          pick_o[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/usb_tx_wire_arb_n.sv
// N-way arbiter in front of the USB wire writer (IDLE/BUSY/GAP).
// Optional watchdog revoke: define USB_TX_ARB_TIMEOUT_EN.
import usb_sie_pkg::*;

module usb_tx_wire_arb_n #(
  parameter int NUM_REQ        = 2,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     reqIn,
  output logic [NUM_REQ-1:0]     gntOut,
  input  logic [2*NUM_REQ-1:0]   dataIn,
  input  logic [NUM_REQ-1:0]     ctrlIn,
  input  logic [NUM_REQ-1:0]     wEnIn,
  input  logic [NUM_REQ-1:0]     fsRateIn,
  output logic [1:0]             TxBits,
  output logic                   TxCtl,
  output logic                   TxFSRate,
  output logic                   USBWireWEn,
  input  logic                   USBWireRdyIn,
  output logic                   USBWireRdyOut,
  output logic                   timeoutErr
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e         state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [IW-1:0]      last_q;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] pick;
  logic               pick_vld;
  logic [IW-1:0]      pick_idx;
  logic               held;
  logic               wen_g;

`ifdef USB_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0]      wd_q;
  logic [NUM_REQ-1:0] mask_q;
  logic               to_q;

  assign elig       = reqIn & ~mask_q;
  assign timeoutErr = to_q;
`else
  assign elig       = reqIn;
  assign timeoutErr = 1'b0;
`endif

  usb_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .elig_i  (elig),
    .last_i  (last_q),
    .mode_i  (1'(ARB_MODE == ARB_RR)),
    .pick_o  (pick),
    .valid_o (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick[i]) pick_idx = IW'(i);
  end

  assign held  = |(reqIn & gnt_q);
  assign wen_g = |(wEnIn & gnt_q);

  always_comb begin
    TxBits     = IDLE_TXBITS;
    TxCtl      = IDLE_TXCTL;
    TxFSRate   = IDLE_FSRATE;
    USBWireWEn = 1'b0;
    if (state_q == ST_BUSY) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt_q[i]) begin
          TxBits     = dataIn[2*i +: 2];
          TxCtl      = ctrlIn[i];
          TxFSRate   = fsRateIn[i];
          USBWireWEn = wEnIn[i];
        end
      end
    end
  end

  assign gntOut        = gnt_q;
  assign USBWireRdyOut = USBWireRdyIn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
`ifdef USB_TX_ARB_TIMEOUT_EN
      wd_q    <= '0;
      mask_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
`ifdef USB_TX_ARB_TIMEOUT_EN
      to_q   <= 1'b0;
      mask_q <= mask_q & reqIn;
`endif
      unique case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            gnt_q   <= pick;
            last_q  <= pick_idx;
            state_q <= ST_BUSY;
`ifdef USB_TX_ARB_TIMEOUT_EN
            wd_q    <= '0;
`endif
          end
        end
        ST_BUSY: begin
          if (!held) begin
            gnt_q   <= '0;
            state_q <= ST_GAP;
          end
`ifdef USB_TX_ARB_TIMEOUT_EN
          else if (wen_g) begin
            wd_q <= '0;
          end else if (wd_q == CW'(TIMEOUT_CYCLES - 1)) begin
            gnt_q   <= '0;
            state_q <= ST_GAP;
            to_q    <= 1'b1;
            mask_q  <= (mask_q & reqIn) | gnt_q;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
